// File: rtl/multiplicacao_seq_5por4.sv
// Purpose: sequential shift-and-add multiplier, unsigned 5-bit a times 4-bit b, 9-bit product s.
// Latency: start accepted at E0, s/done update at E4; back-to-back accept possible at E5.
// Backpressure: start is sampled only in IDLE; start while busy is dropped, not queued.
// Option: define MULT_OVF_FLAG_EN to add the registered ovf output (product wider than 5 bits).

module multiplicacao_seq_5por4 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [4:0] a,
  input  logic [3:0] b,
  output logic [8:0] s,
  output logic       busy,
  output logic       done
`ifdef MULT_OVF_FLAG_EN
  ,
  output logic       ovf
`endif
);

  typedef enum logic {
    IDLE = 1'b0,
    CALC = 1'b1
  } state_t;

  state_t state, state_nxt;

  // Datapath registers and their next values.
  logic [8:0] mcand, mcand_nxt;
  logic [3:0] mplier, mplier_nxt;
  logic [8:0] acc, acc_nxt;
  logic [1:0] cnt, cnt_nxt;
  logic [8:0] s_nxt;
  logic       done_nxt;

  // Partial sum for the current CALC step; 31*15 = 465 never exceeds 9 bits.
  logic [8:0] acc_sum;

`ifdef MULT_OVF_FLAG_EN
  logic ovf_nxt;
`endif

  // busy is exactly "a computation is in flight", so it follows the state.
  assign busy = (state == CALC);

  // Add the multiplicand when the current multiplier LSB is set.
  assign acc_sum = acc + (mplier[0] ? mcand : 9'd0);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and datapath next values; everything holds unless updated below.
  always_comb begin
    state_nxt  = state;
    mcand_nxt  = mcand;
    mplier_nxt = mplier;
    acc_nxt    = acc;
    cnt_nxt    = cnt;
    s_nxt      = s;
    done_nxt   = 1'b0;
`ifdef MULT_OVF_FLAG_EN
    ovf_nxt    = ovf;
`endif
    case (state)
      IDLE: begin
        if (start) begin
          mcand_nxt  = {4'b0000, a};
          mplier_nxt = b;
          acc_nxt    = 9'd0;
          cnt_nxt    = 2'd0;
          state_nxt  = CALC;
        end
      end
      CALC: begin
        acc_nxt    = acc_sum;
        mcand_nxt  = {mcand[7:0], 1'b0};
        mplier_nxt = {1'b0, mplier[3:1]};
        cnt_nxt    = cnt + 2'd1;
        // Last step: publish the sum including this edge's add, no extra DONE state.
        if (cnt == 2'd3) begin
          s_nxt     = acc_sum;
          done_nxt  = 1'b1;
          state_nxt = IDLE;
`ifdef MULT_OVF_FLAG_EN
          ovf_nxt   = (acc_sum[8:5] != 4'd0);
`endif
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Datapath and output registers; reset discards any operation in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand  <= 9'd0;
      mplier <= 4'd0;
      acc    <= 9'd0;
      cnt    <= 2'd0;
      s      <= 9'd0;
      done   <= 1'b0;
    end else begin
      mcand  <= mcand_nxt;
      mplier <= mplier_nxt;
      acc    <= acc_nxt;
      cnt    <= cnt_nxt;
      s      <= s_nxt;
      done   <= done_nxt;
    end
  end

`ifdef MULT_OVF_FLAG_EN
  // Overflow flag travels with s: updated only at completion, cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= 1'b0;
    end else begin
      ovf <= ovf_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_multiplicacao_seq_5por4.sv
// Bench for multiplicacao_seq_5por4: scoreboard of expected products, checked on each done pulse.
// Stimulus is driven on the falling edge; all DUT outputs are sampled on the falling edge.
// Define MULT_OVF_FLAG_EN to also check the ovf output.

module tb_multiplicacao_seq_5por4;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [4:0] a;
  logic [3:0] b;
  logic [8:0] s;
  logic       busy;
  logic       done;
`ifdef MULT_OVF_FLAG_EN
  logic       ovf;
`endif

  int n_checks;
  int n_fail;
  int n_done;
  logic [8:0] last_s;
  logic [8:0] sb_q[$];

  multiplicacao_seq_5por4 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .s     (s),
    .busy  (busy),
    .done  (done)
`ifdef MULT_OVF_FLAG_EN
    ,
    .ovf   (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard: every done pulse must match the oldest outstanding product.
  always @(negedge clk) begin
    if (rst_n && done) begin
      n_done++;
      if (sb_q.size() == 0) begin
        check("done_unexpected", 32'd1, 32'd0);
      end else begin
        logic [8:0] exp_p;
        exp_p = sb_q.pop_front();
        check("product", {23'd0, s}, {23'd0, exp_p});
`ifdef MULT_OVF_FLAG_EN
        check("ovf", {31'd0, ovf}, {31'd0, (exp_p > 9'd31)});
`endif
      end
      last_s = s;
    end
  end

  task automatic push_exp(input logic [4:0] av, input logic [3:0] bv);
    logic [8:0] p;
    p = 9'(av) * 9'(bv);
    sb_q.push_back(p);
  endtask

  // One full operation with busy/done timing and s stability checks.
  task automatic run_op(input logic [4:0] av, input logic [3:0] bv);
    @(negedge clk);
    a = av; b = bv; start = 1'b1;
    push_exp(av, bv);
    @(posedge clk);                       // E0
    @(negedge clk);
    start = 1'b0;
    a = 5'($urandom_range(0, 31));         // operands may change after accept
    b = 4'($urandom_range(0, 15));
    for (int i = 0; i < 4; i++) begin
      check("busy_calc", {31'd0, busy}, 32'd1);
      check("done_early", {31'd0, done}, 32'd0);
      check("s_hold", {23'd0, s}, {23'd0, last_s});
      @(negedge clk);
    end
    check("busy_end", {31'd0, busy}, 32'd0);   // after E4
    check("done_pulse", {31'd0, done}, 32'd1);
    @(negedge clk);
    check("done_once", {31'd0, done}, 32'd0);
  endtask

  initial begin
    int d0;
    n_checks = 0; n_fail = 0; n_done = 0; last_s = 9'd0;
    rst_n = 1'b0; start = 1'b0; a = 5'd0; b = 4'd0;
    repeat (2) @(negedge clk);
    check("rst_s", {23'd0, s}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
`ifdef MULT_OVF_FLAG_EN
    check("rst_ovf", {31'd0, ovf}, 32'd0);
`endif
    rst_n = 1'b1;
    @(negedge clk);

    // Directed operands, including zero operands and the maximum product.
    run_op(5'd7, 4'd3);
    run_op(5'd31, 4'd15);
    run_op(5'd0, 4'd9);
    run_op(5'd13, 4'd0);
    for (int k = 0; k < 6; k++) begin
      run_op(5'($urandom_range(0, 31)), 4'($urandom_range(0, 15)));
    end

    // start while busy is ignored.
    d0 = n_done;
    @(negedge clk);
    a = 5'd5; b = 4'd6; start = 1'b1;
    push_exp(5'd5, 4'd6);
    @(posedge clk);                       // E0
    @(negedge clk); start = 1'b0;
    @(negedge clk);                       // after E1
    a = 5'd31; b = 4'd15; start = 1'b1;   // held across E2, E3
    @(negedge clk);
    @(negedge clk);                       // after E3
    start = 1'b0;
    @(negedge clk);                       // after E4
    check("ign_done", {31'd0, done}, 32'd1);
    check("ign_s", {23'd0, s}, 32'd30);
    @(negedge clk);
    check("ign_busy", {31'd0, busy}, 32'd0);
    repeat (4) @(negedge clk);
    check("ign_done_cnt", n_done - d0, 32'd1);

    // Back-to-back: start held high through the done cycle.
    @(negedge clk);
    a = 5'd3; b = 4'd2; start = 1'b1;
    push_exp(5'd3, 4'd2);
    @(posedge clk);                       // E0
    repeat (4) @(negedge clk);            // after E3
    check("b2b_busy1", {31'd0, busy}, 32'd1);
    @(negedge clk);                       // after E4, done cycle
    check("b2b_done1", {31'd0, done}, 32'd1);
    check("b2b_s1", {23'd0, s}, 32'd6);
    a = 5'd4; b = 4'd4;
    push_exp(5'd4, 4'd4);
    @(negedge clk);                       // after E5 = second accept
    start = 1'b0;
    check("b2b_busy2", {31'd0, busy}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      check("b2b_s_hold", {23'd0, s}, 32'd6);
      @(negedge clk);
    end
    check("b2b_s_hold", {23'd0, s}, 32'd6);
    @(negedge clk);                       // four edges after second accept
    check("b2b_done2", {31'd0, done}, 32'd1);
    check("b2b_s2", {23'd0, s}, 32'd16);
    @(negedge clk);

    // Reset mid-computation discards the operation.
    @(negedge clk);
    a = 5'd31; b = 4'd15; start = 1'b1;
    @(posedge clk);                       // E0
    @(negedge clk); start = 1'b0;
    @(posedge clk);                       // E1
    @(posedge clk);                       // E2
    #1 rst_n = 1'b0;
    #1;
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_s", {23'd0, s}, 32'd0);
    check("arst_done", {31'd0, done}, 32'd0);
`ifdef MULT_OVF_FLAG_EN
    check("arst_ovf", {31'd0, ovf}, 32'd0);
`endif
    last_s = 9'd0;
    d0 = n_done;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    check("arst_no_done", n_done - d0, 32'd0);
    check("arst_idle", {31'd0, busy}, 32'd0);

    // A fresh operation works after reset.
    run_op(5'd9, 4'd11);

    check("sb_drained", sb_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
